gauss_win_sched: RTL and testbench
==================================

# gauss_win_sched

Raster-to-window scheduler for the 5x5 Gaussian convolution datapath in the Canny front end. It accepts a pixel stream under valid/ready, stores rows in a ring of six line buffers, and replays each completed 5-row band to the convolution's 5-lane `dd` input as an uninterrupted burst. The convolution has no enable or valid and must never see a stall mid-row. The block tags the convolution's `dout` with `out_valid`, `out_eol` and `out_eof`, so downstream non-max suppression sees only fully populated windows.

## Interface
- `DW`, 8: pixel width.
- `MAX_W`, 1024: maximum line width, which sets the depth of each line buffer.
- `AW`, 10: column address width; clog2(MAX_W).
- `HW`, 12: row counter width.
- `CONV_LAT`, 13: cycles from a column on `dd` to the matching convolution `dout`.
- `clk` in 1: single clock, rising edge.
- `rst_b` in 1: reset, asynchronous and active-low; clears all state.
- `start` in 1: pulse that latches the configuration and begins a frame.
- `cfg_w` in AW+1: frame width in pixels.
- `cfg_h` in HW: frame height in rows.
- `pix_in` in DW: input pixel.
- `pix_valid` in 1: input valid.
- `pix_ready` out 1: input ready.
- `dd` out 5*DW: window column to the convolution; lane 0 = row r-4 (oldest), lane 4 = row r.
- `conv_dout` in DW: convolution result.
- `out_pix` out DW: equals `conv_dout`, combinational.
- `out_valid` out 1: `out_pix` is a valid filtered pixel.
- `out_eol` out 1: last valid pixel of an output row.
- `out_eof` out 1: last valid pixel of the frame.
- `busy` out 1: a frame is in progress.
- `done` out 1: one-cycle pulse at frame completion.
- `cfg_err` out 1: one-cycle pulse when `start` carries an illegal configuration.

## Operation
- Reset values:
  - `pix_ready`, `out_valid`, `out_eol`, `out_eof`, `busy`, `done`, `cfg_err`, `dd` are all 0.
  - The FSM is in IDLE.
  - All counters are 0 and the tag pipe is cleared.
- Main FSM states:
  - IDLE: legal `start` moves to FILL and asserts `busy`; `start` outside IDLE is ignored.
  - FILL: rows 0..3 are written; there are no bursts.
  - RUN: rows are written and bursts are issued.
  - DRAIN: wait CONV_LAT+1 cycles after the last burst.
  - DONE: pulse `done` for one cycle, then return to IDLE.
- Configuration legality: legal iff 5 <= `cfg_w` <= MAX_W and `cfg_h` >= 5. Otherwise pulse `cfg_err` and stay in IDLE.
- Writer:
  - Each accepted pixel (`pix_valid` & `pix_ready`) is written to slot (wr_row mod 6) at address wr_col.
  - wr_col wraps at `cfg_w`-1 and increments wr_row.
  - After row `cfg_h`-1, `pix_ready` = 0 until the next frame.
- Writer stall rule: row w (w >= 6) overwrites row w-6, which is needed by the bursts for rows up to w-2. `pix_ready` = 0 while wr_row >= 6 and the burst for row wr_row-2 has not completed.
- Burst start: a burst for row r (r >= 4) starts the cycle after both of the following hold:
  - row r is fully written;
  - the burst for row r-1 has finished (or r = 4).
  - If both become true in the same cycle, the burst still starts the next cycle.
- Burst execution:
  - Issues column addresses 0..`cfg_w`-1 on consecutive cycles, with no gaps and no dependence on input.
  - Line buffers have a 1-cycle read latency, so `dd` is registered and column c appears one cycle after its address.
  - Lanes 0..4 are read from slots (r-4..r) mod 6.
- Between bursts `dd` holds its last value; the associated tags are 0.
- Tagging:
  - Each `dd` column carries tag valid = (c >= 4), eol = (c = `cfg_w`-1), and eof = eol & (r = `cfg_h`-1).
  - Tags pass through a CONV_LAT-deep shift register to `out_valid`, `out_eol`, `out_eof`.
- Output frame is (`cfg_w`-4) x (`cfg_h`-4); each output pixel corresponds to the window centred at (r-2, c-2).

## Timing
- `dd` column c at cycle t produces `out_pix` with its tags at t+CONV_LAT.
- First output pixel: row 4 completes at edge T. Column 0 appears on `dd` at T+2, so the first `out_valid` is at T+2+4+CONV_LAT = T+19 with defaults.
- Burst length is exactly `cfg_w` cycles. Back-to-back bursts are separated by at least one idle cycle.
- `done` asserts CONV_LAT+2 cycles after the last `dd` column. `busy` deasserts together with `done`.
- Reset asserted mid-frame: all outputs go to their reset values immediately (asynchronously). Line buffer contents are don't-care. The next frame requires a new `start`.
- `start` and `pix_valid` in the same cycle: the pixel is not accepted; `pix_ready` first rises the cycle after `start`.

## Test plan
- Legal 8x6 frame, pixel = 16*row+col, `pix_valid` held high:
  - exactly 8 `out_valid` beats (4x2);
  - `out_eol` on the 4th and 8th beats, `out_eof` on the 8th;
  - first `out_valid` at row-4-complete + 19 cycles;
  - the `dd` lanes for the column issued from address 5 of the row 4 burst are {0x05,0x15,0x25,0x35,0x45}, lane 0 first.
- Continuous 12x10 frame, `pix_valid` always high: `pix_ready` drops only under the stall rule, and a burst is never interrupted.
- Random `pix_valid` gaps: outputs and `dd` match the gapless case beat-for-beat; only absolute cycle positions shift.
- `start` with `cfg_w`=4: `cfg_err` pulses for one cycle, `busy` stays 0. Then `start` with `cfg_w`=MAX_W, `cfg_h`=5: one output row of MAX_W-4 pixels.
- Assert `rst_b`=0 mid-burst on row 6: all outputs go to 0 in the same cycle. A fresh 8x6 frame afterwards passes the first scenario.
- Pulse `start` while `busy`: ignored; the current frame completes normally with one `done`.

Source files
------------

// File: rtl/gauss_win_sched.sv
// Raster-to-window scheduler for the 5x5 Gaussian convolution: six-row line-buffer
// ring, gapless 5-row column bursts to the convolution, and tag alignment on its output.
module gauss_win_sched #(
  parameter int DW       = 8,
  parameter int MAX_W    = 1024,
  parameter int AW       = 10,
  parameter int HW       = 12,
  parameter int CONV_LAT = 13
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            start,
  input  logic [AW:0]     cfg_w,
  input  logic [HW-1:0]   cfg_h,
  input  logic [DW-1:0]   pix_in,
  input  logic            pix_valid,
  output logic            pix_ready,
  output logic [5*DW-1:0] dd,
  input  logic [DW-1:0]   conv_dout,
  output logic [DW-1:0]   out_pix,
  output logic            out_valid,
  output logic            out_eol,
  output logic            out_eof,
  output logic            busy,
  output logic            done,
  output logic            cfg_err
);
  localparam int CW = $clog2(CONV_LAT + 1);

  typedef enum logic [2:0] {IDLE, FILL, RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [AW:0]          w_cfg;
  logic [HW-1:0]        h_cfg;
  logic [AW-1:0]        wr_col, rd_col;
  logic [HW-1:0]        wr_row, br_row;
  logic [2:0]           wr_slot, rd_base, lane_sel;
  logic                 burst_act;
  logic                 cfg_ok, start_ok, stall, accept, wr_last, burst_go, burst_last;
  logic [5:0][DW-1:0]   rd_all;
  logic [3:0]           lane_idx;
  logic                 vld_p0, eol_p0, eof_p0;
  logic [CONV_LAT-1:0]  vld_pipe, eol_pipe, eof_pipe;
  logic [CW-1:0]        drain_cnt;

  assign cfg_ok   = (cfg_w >= (AW+1)'(5)) && (cfg_w <= (AW+1)'(MAX_W)) && (cfg_h >= HW'(5));
  assign start_ok = (state == IDLE) && start && cfg_ok;

  // Row w reuses the slot of row w-6, which the bursts for rows up to w-2 still read.
  assign stall      = (wr_row >= HW'(6)) && (br_row <= wr_row - HW'(2));
  assign pix_ready  = ((state == FILL) || (state == RUN)) && (wr_row < h_cfg) && !stall;
  assign accept     = pix_ready && pix_valid;
  assign wr_last    = ({1'b0, wr_col} == w_cfg - (AW+1)'(1));
  assign burst_go   = (state == RUN) && !burst_act && (br_row < h_cfg) && (wr_row > br_row);
  assign burst_last = burst_act && ({1'b0, rd_col} == w_cfg - (AW+1)'(1));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      w_cfg   <= '0;
      h_cfg   <= '0;
      wr_col  <= '0;
      wr_row  <= '0;
      wr_slot <= '0;
    end else if (start_ok) begin
      w_cfg   <= cfg_w;
      h_cfg   <= cfg_h;
      wr_col  <= '0;
      wr_row  <= '0;
      wr_slot <= '0;
    end else if (accept) begin
      if (wr_last) begin
        wr_col  <= '0;
        wr_row  <= wr_row + HW'(1);
        wr_slot <= (wr_slot == 3'd5) ? 3'd0 : wr_slot + 3'd1;
      end else begin
        wr_col  <= wr_col + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      burst_act <= 1'b0;
      rd_col    <= '0;
      br_row    <= '0;
      rd_base   <= '0;
      lane_sel  <= '0;
    end else if (start_ok) begin
      burst_act <= 1'b0;
      rd_col    <= '0;
      br_row    <= HW'(4);
      rd_base   <= '0;
    end else if (burst_go) begin
      burst_act <= 1'b1;
      rd_col    <= '0;
      lane_sel  <= rd_base;
    end else if (burst_act) begin
      if (burst_last) begin
        burst_act <= 1'b0;
        rd_col    <= '0;
        br_row    <= br_row + HW'(1);
        rd_base   <= (rd_base == 3'd5) ? 3'd0 : rd_base + 3'd1;
      end else begin
        rd_col    <= rd_col + AW'(1);
      end
    end
  end

  // Stage p0: line-buffer read register; holds the last column between bursts.
  for (genvar s = 0; s < 6; s++) begin : g_slot
    logic [DW-1:0] mem [MAX_W];
    logic [DW-1:0] q;
    always_ff @(posedge clk) begin
      if (accept && (wr_slot == 3'(s))) mem[wr_col] <= pix_in;
    end
    always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b)         q <= '0;
      else if (burst_act) q <= mem[rd_col];
    end
    assign rd_all[s] = q;
  end

  always_comb begin
    dd       = '0;
    lane_idx = '0;
    for (int i = 0; i < 5; i++) begin
      lane_idx = {1'b0, lane_sel} + 4'(i);
      if (lane_idx >= 4'd6) lane_idx = lane_idx - 4'd6;
      dd[i*DW +: DW] = rd_all[lane_idx[2:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      vld_p0   <= 1'b0;
      eol_p0   <= 1'b0;
      eof_p0   <= 1'b0;
      vld_pipe <= '0;
      eol_pipe <= '0;
      eof_pipe <= '0;
    end else begin
      vld_p0   <= burst_act && (rd_col >= AW'(4));
      eol_p0   <= burst_last;
      eof_p0   <= burst_last && (br_row == h_cfg - HW'(1));
      // Stages p1..pCONV_LAT: tags ride alongside the convolution latency.
      vld_pipe <= {vld_pipe[CONV_LAT-2:0], vld_p0};
      eol_pipe <= {eol_pipe[CONV_LAT-2:0], eol_p0};
      eof_pipe <= {eof_pipe[CONV_LAT-2:0], eof_p0};
    end
  end

  assign out_pix   = conv_dout;
  assign out_valid = vld_pipe[CONV_LAT-1];
  assign out_eol   = eol_pipe[CONV_LAT-1];
  assign out_eof   = eof_pipe[CONV_LAT-1];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= IDLE;
      drain_cnt <= '0;
      cfg_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == DRAIN) ? drain_cnt + CW'(1) : '0;
      cfg_err   <= (state == IDLE) && start && !cfg_ok;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = FILL;
      FILL:    if (wr_row >= HW'(4)) state_nxt = RUN;
      RUN:     if (!burst_act && (br_row == h_cfg)) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == CW'(CONV_LAT)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == FILL) || (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_gauss_win_sched.sv
// Directed bench for gauss_win_sched; a stub convolution folds each dd column into
// one byte so out_pix exposes lane order and column alignment.
module tb_gauss_win_sched;
  localparam int DW = 8, MAX_W = 1024, AW = 10, HW = 12, CONV_LAT = 13;

  logic            clk = 1'b0;
  logic            rst_b = 1'b0;
  logic            start = 1'b0;
  logic [AW:0]     cfg_w = '0;
  logic [HW-1:0]   cfg_h = '0;
  logic [DW-1:0]   pix_in = '0;
  logic            pix_valid = 1'b0;
  logic            pix_ready;
  logic [5*DW-1:0] dd;
  logic [DW-1:0]   conv_dout, out_pix;
  logic            out_valid, out_eol, out_eof, busy, done, cfg_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gauss_win_sched #(.DW(DW), .MAX_W(MAX_W), .AW(AW), .HW(HW), .CONV_LAT(CONV_LAT)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .cfg_w(cfg_w), .cfg_h(cfg_h),
    .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready), .dd(dd),
    .conv_dout(conv_dout), .out_pix(out_pix), .out_valid(out_valid), .out_eol(out_eol),
    .out_eof(out_eof), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] pv(input int r, input int c);
    return 8'(16 * r + c);
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    if (n == 0) return v;
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  function automatic logic [7:0] mix(input logic [39:0] col);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < 5; k++) r = r ^ rotl(col[k*8 +: 8], k);
    return r;
  endfunction

  // Stub convolution: a CONV_LAT-cycle delay of a lane-order-sensitive fold of dd.
  logic [7:0] cpipe [CONV_LAT];
  always @(posedge clk) begin
    cpipe[0] <= mix(dd);
    for (int i = 1; i < CONV_LAT; i++) cpipe[i] <= cpipe[i-1];
  end
  assign conv_dout = cpipe[CONV_LAT-1];

  int cur_w = 8, cur_h = 6;
  int beats = 0, dones = 0, first_vld = -1, prev_vld = 0, t_row4 = -100000;
  logic [39:0] dd_cap = '0;

  always @(negedge clk) begin
    int orow, ocol, c;
    if (cyc == t_row4 + 7) dd_cap = dd;
    if (done) begin
      dones++;
      chk("busy_at_done", 64'(busy), 64'(0));
    end
    if (out_valid) begin
      orow = beats / (cur_w - 4);
      ocol = beats % (cur_w - 4);
      c    = ocol + 4;
      if (beats == 0) first_vld = cyc;
      chk("out_pix", 64'(out_pix),
          64'(mix({pv(orow+4, c), pv(orow+3, c), pv(orow+2, c), pv(orow+1, c), pv(orow, c)})));
      chk("out_eol", 64'(out_eol), 64'(ocol == cur_w - 5));
      chk("out_eof", 64'(out_eof), 64'((ocol == cur_w - 5) && (orow == cur_h - 5)));
      if (ocol > 0) chk("row_gapless", 64'(cyc - prev_vld), 64'(1));
      prev_vld = cyc;
      beats++;
    end else if (out_eol || out_eof) begin
      chk("tag_without_valid", 64'({out_eol, out_eof}), 64'(0));
    end
  end

  task automatic run_frame(input int w, input int h, input bit gaps, input bit mid_start,
                           input bit timing, input bit abort);
    int idx, budget, after;
    bit early_drop;
    cur_w = w; cur_h = h;
    beats = 0; dones = 0; first_vld = -1; t_row4 = -100000; dd_cap = '0;
    @(negedge clk);
    start = 1'b1; cfg_w = (AW+1)'(w); cfg_h = HW'(h); pix_valid = 1'b1; pix_in = 8'hEE;
    chk("rdy_at_start", 64'(pix_ready), 64'(0));
    idx = 0; budget = 0; after = 0; early_drop = 1'b0;
    while (idx < w * h && budget < 40000) begin
      @(negedge clk);
      budget++;
      start = 1'b0;
      if (mid_start && idx == 3 * w) begin
        start = 1'b1; cfg_w = (AW+1)'(6); cfg_h = HW'(5);
      end
      pix_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      pix_in    = pv(idx / w, idx % w);
      if (!pix_ready && idx < 6 * w) early_drop = 1'b1;
      if (pix_valid && pix_ready) begin
        idx++;
        if (idx == 5 * w) t_row4 = cyc + 1;
      end
      if (abort && idx >= 7 * w) begin
        after++;
        if (after == 8) break;
      end
    end
    if (abort) begin
      chk("busy_before_reset", 64'(busy), 64'(1));
      #2 rst_b = 1'b0;
      #1;
      chk("rst_dd", 64'(dd), 64'(0));
      chk("rst_pix_ready", 64'(pix_ready), 64'(0));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_eol", 64'(out_eol), 64'(0));
      chk("rst_out_eof", 64'(out_eof), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_cfg_err", 64'(cfg_err), 64'(0));
      pix_valid = 1'b0;
      @(negedge clk);
      rst_b = 1'b1;
      return;
    end
    @(negedge clk);
    pix_valid = 1'b0;
    chk("pixels_accepted", 64'(idx), 64'(w * h));
    budget = 0;
    while (dones == 0 && budget < 8000) begin
      @(negedge clk);
      budget++;
    end
    chk("done_seen", 64'(dones), 64'(1));
    repeat (30) @(negedge clk);
    chk("done_once", 64'(dones), 64'(1));
    chk("beat_count", 64'(beats), 64'((w - 4) * (h - 4)));
    chk("busy_after", 64'(busy), 64'(0));
    chk("ready_rows0_5", 64'(early_drop), 64'(0));
    if (timing) begin
      chk("first_vld_latency", 64'(first_vld - t_row4), 64'(19));
      chk("dd_row4_col5", 64'(dd_cap), 64'(40'h45_35_25_15_05));
    end
  endtask

  task automatic bad_start(input int w, input int h);
    @(negedge clk);
    start = 1'b1; cfg_w = (AW+1)'(w); cfg_h = HW'(h);
    @(negedge clk);
    start = 1'b0;
    chk("cfg_err_pulse", 64'(cfg_err), 64'(1));
    chk("cfg_err_busy", 64'(busy), 64'(0));
    @(negedge clk);
    chk("cfg_err_one_cycle", 64'(cfg_err), 64'(0));
    chk("cfg_err_idle", 64'(busy), 64'(0));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_dd", 64'(dd), 64'(0));
    chk("reset_flags", 64'({pix_ready, out_valid, out_eol, out_eof, busy, done, cfg_err}), 64'(0));
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(8, 6, 1'b0, 1'b0, 1'b1, 1'b0);
    run_frame(12, 10, 1'b0, 1'b1, 1'b0, 1'b0);
    run_frame(8, 6, 1'b1, 1'b0, 1'b0, 1'b0);
    bad_start(4, 6);
    bad_start(8, 4);
    bad_start(MAX_W + 1, 6);
    run_frame(MAX_W, 5, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(8, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    run_frame(8, 6, 1'b0, 1'b0, 1'b1, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
